// File: rtl/mdu_iterative.sv
// RV32M multiply/divide unit: fixed-latency multiply, iterative radix-2 restoring divide.
// One op in flight; ready_o in IDLE/DONE lets a new op start in the completion cycle.
//
// state | meaning
// IDLE  | waiting for an op
// MUL   | multiply product registered, waiting out the remaining latency
// DIV   | one restoring-divide iteration per cycle, XLEN iterations
// FIX   | apply quotient/remainder sign correction
// DONE  | result valid, done_o asserted for this cycle
module mdu_iterative #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  op_a_i,
  input  logic [XLEN-1:0]  op_b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0]  XMIN    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   quo_q, rem_q, dvs_q;
  logic [TAG_W-1:0]  tag_q;
  logic              mul_hi_q, is_rem_q, neg_quo_q, neg_rem_q;

  logic              accept;
  logic              is_div_i, div_signed_i, is_rem_i, mul_hi_i;
  logic              a_sx, b_sx;
  logic              div_zero, div_ovf, div_special;
  logic [XLEN-1:0]   mag_a, mag_b, special_res;
  logic [2*XLEN-1:0] a_wide, b_wide, prod_i;

  logic [XLEN-1:0]   trial_lo, diff, fix_res;
  logic              trial_ge;

  function automatic logic [XLEN-1:0] mul_sel(input logic hi, input logic [2*XLEN-1:0] p);
    return hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
  endfunction

  assign ready_o = (state == S_IDLE) || (state == S_DONE);
  assign busy_o  = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign done_o  = (state == S_DONE) && !flush_i;
  assign accept  = start_i && ready_o && !flush_i;

  assign is_div_i     = funct3_i[2];
  assign div_signed_i = ~funct3_i[0];
  assign is_rem_i     = funct3_i[1];
  assign mul_hi_i     = (funct3_i[1:0] != 2'b00);

  // Extending with the sign bit into 2*XLEN gives the same low 2*XLEN product bits
  // as a full signed (XLEN+1)-bit multiply, which is all MUL/MULH* ever read.
  assign a_sx   = op_a_i[XLEN-1] & (funct3_i[1] ^ funct3_i[0]);
  assign b_sx   = op_b_i[XLEN-1] & (funct3_i[1:0] == 2'b01);
  assign a_wide = {{XLEN{a_sx}}, op_a_i};
  assign b_wide = {{XLEN{b_sx}}, op_b_i};
  assign prod_i = a_wide * b_wide;

  assign mag_a = (div_signed_i && op_a_i[XLEN-1]) ? -op_a_i : op_a_i;
  assign mag_b = (div_signed_i && op_b_i[XLEN-1]) ? -op_b_i : op_b_i;

  assign div_zero    = (op_b_i == '0);
  assign div_ovf     = div_signed_i && (op_a_i == XMIN) && (op_b_i == '1);
  assign div_special = div_zero || div_ovf;
  assign special_res = div_zero ? (is_rem_i ? op_a_i : '1)
                                : (is_rem_i ? '0 : XMIN);

  // The partial remainder is always below the divisor, so the XLEN-bit
  // difference is exact whenever the trial subtraction succeeds.
  assign trial_lo = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  assign trial_ge = {rem_q[XLEN-1], trial_lo} >= {1'b0, dvs_q};
  assign diff     = trial_lo - dvs_q;

  assign fix_res = is_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                            : (neg_quo_q ? -quo_q : quo_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (!is_div_i)        state_nxt = (MUL_LATENCY == 1) ? S_DONE : S_MUL;
          else if (div_special) state_nxt = S_DONE;
          else                  state_nxt = S_DIV;
        end else if (state == S_DONE) begin
          state_nxt = S_IDLE;
        end
      end
      S_MUL:   if (cnt == '0) state_nxt = S_DONE;
      S_DIV:   if (cnt == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush_i) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      prod_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      tag_q     <= '0;
      mul_hi_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= '0;
      tag_o     <= '0;
    end else if (accept) begin
      tag_q     <= tag_i;
      mul_hi_q  <= mul_hi_i;
      is_rem_q  <= is_rem_i;
      neg_quo_q <= div_signed_i && (op_a_i[XLEN-1] ^ op_b_i[XLEN-1]);
      neg_rem_q <= div_signed_i && op_a_i[XLEN-1];
      prod_q    <= prod_i;
      quo_q     <= mag_a;
      rem_q     <= '0;
      dvs_q     <= mag_b;
      cnt       <= is_div_i ? DIV_CNT : MUL_CNT;
      if (is_div_i && div_special) begin
        result_o <= special_res;
        tag_o    <= tag_i;
      end else if (!is_div_i && (MUL_LATENCY == 1)) begin
        result_o <= mul_sel(mul_hi_i, prod_i);
        tag_o    <= tag_i;
      end
    end else begin
      case (state)
        S_MUL: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!flush_i) begin
            result_o <= mul_sel(mul_hi_q, prod_q);
            tag_o    <= tag_q;
          end
        end
        S_DIV: begin
          quo_q <= {quo_q[XLEN-2:0], trial_ge};
          rem_q <= trial_ge ? diff : trial_lo;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          if (!flush_i) begin
            result_o <= fix_res;
            tag_o    <= tag_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed vectors with hand-computed results
// and completion edges; a negedge monitor pops and compares on every done_o.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] op_a_i = 32'd0;
  logic [31:0] op_b_i = 32'd0;
  logic [4:0]  tag_i = 5'd0;
  logic        ready_o, busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  tag_o;

  mdu_iterative #(.XLEN(32), .MUL_LATENCY(2), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .funct3_i(funct3_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .tag_i(tag_i), .flush_i(flush_i),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;
  vec_t vq[$];

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'(done_o), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", result_o, e.res);
        chk("tag", 32'(tag_o), 32'(e.tag));
        chk("done_edge", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tg, input logic [31:0] expv, input int lat,
                       input bit push, output int acc);
    int w;
    exp_t e;
    w = 0;
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = f3;
    op_a_i   = a;
    op_b_i   = b;
    tag_i    = tg;
    while (!ready_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!ready_o) begin
      chk("accept_timeout", 32'(ready_o), 32'd1);
      start_i = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (push) begin
      e.res = expv;
      e.tag = tg;
      e.cyc = acc + lat - 1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    start_i  = 1'b0;
    funct3_i = 3'($urandom);
    op_a_i   = $urandom;
    op_b_i   = $urandom;
    tag_i    = 5'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    chk("sb_drain", sbq.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, acc2;

    vq.push_back('{3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 2});
    vq.push_back('{3'b001, 32'h80000000,  32'h80000000, 32'h40000000, 2});
    vq.push_back('{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 2});
    vq.push_back('{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 2});
    vq.push_back('{3'b001, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF, 2});
    vq.push_back('{3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 34});
    vq.push_back('{3'b101, 32'd5,         32'd0,        32'hFFFFFFFF, 1});
    vq.push_back('{3'b111, 32'd5,         32'd0,        32'd5,        1});
    vq.push_back('{3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1});
    vq.push_back('{3'b110, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1});
    vq.push_back('{3'b110, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFF9, 1});
    vq.push_back('{3'b101, 32'd100,       32'd7,        32'd14,       34});
    vq.push_back('{3'b111, 32'd100,       32'd7,        32'd2,        34});
    vq.push_back('{3'b100, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 34});
    vq.push_back('{3'b110, 32'd7,         32'hFFFFFFFE, 32'd1,        34});
    vq.push_back('{3'b101, 32'hFFFFFFF9,  32'd2,        32'h7FFFFFFC, 34});

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_result", result_o, 32'd0);
    chk("reset_tag", 32'(tag_o), 32'd0);

    // Signed divide with busy profile: busy after edges 1..33, DONE after edge 34.
    issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd20, 32'hFFFFFFFD, 34, 1'b1, acc);
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      chk("div_busy", 32'(busy_o), (i <= 32) ? 32'd1 : 32'd0);
      if (i == 33) chk("div_ready_in_done", 32'(ready_o), 32'd1);
    end

    foreach (vq[i])
      issue(vq[i].f3, vq[i].a, vq[i].b, 5'(i + 1), vq[i].res, vq[i].lat, 1'b1, acc);
    drain();

    // Second op held during a divide must be taken exactly in the DONE cycle.
    issue(3'b100, 32'd100, 32'hFFFFFFF9, 5'd3, 32'hFFFFFFF2, 34, 1'b1, acc1);
    issue(3'b000, 32'd6, 32'd7, 5'd9, 32'd42, 2, 1'b1, acc2);
    chk("b2b_accept_edge", acc2, acc1 + 34);
    drain();

    // Flush sampled at edge 10 of a DIVU: no completion, outputs hold.
    issue(3'b101, 32'd1000, 32'd3, 5'd7, 32'd0, 34, 1'b0, acc);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_ready", 32'(ready_o), 32'd1);
    chk("flush_busy", 32'(busy_o), 32'd0);
    chk("flush_result_hold", result_o, 32'd42);
    chk("flush_tag_hold", 32'(tag_o), 32'd9);
    repeat (40) @(negedge clk);
    issue(3'b000, 32'd3, 32'd4, 5'd12, 32'd12, 2, 1'b1, acc);
    drain();

    // Flush together with start: no accept.
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b000; op_a_i = 32'd5; op_b_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_no_accept", 32'(busy_o), 32'd0);
    repeat (4) @(negedge clk);

    // Async reset mid-divide clears outputs at once and kills the op.
    issue(3'b100, 32'h12345678, 32'd3, 5'd17, 32'd0, 34, 1'b0, acc);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_result", result_o, 32'd0);
    chk("rst_tag", 32'(tag_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_ready", 32'(ready_o), 32'd1);
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    chk("sb_final", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised RV32M multiply/divide unit; successor to the combinational ALU control decode, which has no M-extension path.
- Decodes funct3 for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Multiply uses a fixed-latency pipeline; divide uses an iterative radix-2 restoring engine.
- Sits beside the ALU in EX; the hazard unit stalls the pipeline while busy_o=1.

Parameters:
- XLEN, 32, operand/result width (supported: 8..64, even).
- MUL_LATENCY, 2, edges from accept to done_o for multiplies (1..4).
- TAG_W, 5, width of destination-register tag carried with the op.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  op request; accepted when start_i=1 and ready_o=1 and flush_i=0.
- funct3_i  in  3  M-extension funct3 (000 MUL … 111 REMU).
- op_a_i  in  XLEN  rs1 value / dividend.
- op_b_i  in  XLEN  rs2 value / divisor.
- tag_i  in  TAG_W  rd tag.
- flush_i  in  1  synchronous abort (branch mispredict/trap).
- ready_o  out  1  can accept an op this cycle.
- busy_o  out  1  op in flight (MUL, DIV or FIX state).
- done_o  out  1  one-cycle result-valid pulse.
- result_o  out  XLEN  result; held stable until the next done_o.
- tag_o  out  TAG_W  tag of the completed op; held with result_o.

Behaviour:
- Async reset (rst_n=0): state IDLE, counter 0, done_o=0, busy_o=0, result_o=0, tag_o=0, ready_o=1 once reset is released.
- Reset mid-operation discards the op; no done_o follows.
- States:
  - IDLE: on accept, funct3[2]=0 goes to MUL; funct3[2]=1 goes to DONE if a divide special case applies, else DIV.
  - MUL: counts MUL_LATENCY-1 cycles, then DONE.
  - DIV: XLEN iterations, then FIX.
  - FIX: sign correction, then DONE.
  - DONE: asserts done_o for one cycle; next state is IDLE, or a new op if one is accepted in DONE.
- ready_o = (state==IDLE or DONE). busy_o = (state is MUL, DIV or FIX).
- start_i while ready_o=0 is ignored; requester must hold start_i.
- Latency, counted as edges from the accept edge to the edge that raises done_o:
  - multiply: MUL_LATENCY
  - normal divide: XLEN+2
  - divide special case: 1
- Multiply: operands extend to XLEN+1 bits; signed for MULH (a,b), MULHSU (a only); unsigned otherwise. Signed 2XLEN+2 product.
  - MUL returns product[XLEN-1:0].
  - MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
- Divide:
  - Operands latched at accept as magnitudes; signs of quotient and remainder recorded (DIV/REM only).
  - Quotient negated if sign(a)≠sign(b); remainder takes sign of dividend.
- Divide special cases:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return op_a_i.
  - DIV with 0x80..0 / -1: returns 0x80..0; REM returns 0.
- Flush:
  - flush_i=1 forces IDLE on the next edge from any state.
  - Suppresses done_o in that cycle and after it.
  - result_o/tag_o are unchanged.
  - Flush in the same cycle as start_i means no accept.
- Operands and funct3 are latched at accept; later input changes have no effect.

Test Plan (XLEN=32, MUL_LATENCY=2):
- Multiplies:
  - MUL 7×0xFFFFFFFD → result 0xFFFFFFEB; done_o high exactly 2 edges after accept, for one cycle.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; done_o at edge 34; busy_o high edges 1–33.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
  - All four complete at edge 1.
- Back-to-back: second start held during a divide is ignored until DONE; accepted in DONE; tag_o tracks each op (tags 3 then 9).
- Flush at edge 10 of a DIVU:
  - No done_o ever.
  - ready_o=1 next cycle; result_o retains previous value.
  - Following MUL 3×4 → 12 at its edge 2.
- Reset: rst_n low mid-divide → outputs zero immediately (async); no done_o after release.
